// File: rtl/rr_mux_sched.sv
// Round-robin 8:1 mux scheduler: one owner at a time, each grant bounded by
// HOLD cycles and followed by a mandatory idle cycle before the next grant.
module rr_mux_sched #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,    // owner done; "release" is a reserved word
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       grant_end;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_end = rel || !req[sel] || (cnt == 4'(HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= 4'd0;
      sel   <= 3'd0;
      grant <= 8'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= win;
            grant <= 8'd1 << win;
            busy  <= 1'b1;
            cnt   <= 4'd0;
            state <= OWN;
          end
        end
        OWN: begin
          // Ending always passes through IDLE, which yields the dead cycle.
          if (grant_end) begin
            grant <= 8'd0;
            busy  <= 1'b0;
            ptr   <= sel + 3'd1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
